// File: rtl/alu_pkg.sv
// Shared encodings for alu_mdu: aluop/funct constants, internal alucontrol codes,
// FSM states and the aluop/funct decoder.
package alu_pkg;

  localparam logic [1:0] AluopAdd   = 2'b00;
  localparam logic [1:0] AluopSub   = 2'b01;
  localparam logic [1:0] AluopFunct = 2'b10;
  localparam logic [1:0] AluopRsvd  = 2'b11;

  localparam logic [5:0] FunctAdd   = 6'b100000;
  localparam logic [5:0] FunctSub   = 6'b100010;
  localparam logic [5:0] FunctAnd   = 6'b100100;
  localparam logic [5:0] FunctOr    = 6'b100101;
  localparam logic [5:0] FunctXor   = 6'b100110;
  localparam logic [5:0] FunctNor   = 6'b100111;
  localparam logic [5:0] FunctSlt   = 6'b101010;
  localparam logic [5:0] FunctSltu  = 6'b101011;
  localparam logic [5:0] FunctMfhi  = 6'b010000;
  localparam logic [5:0] FunctMflo  = 6'b010010;
  localparam logic [5:0] FunctMult  = 6'b011000;
  localparam logic [5:0] FunctMultu = 6'b011001;
  localparam logic [5:0] FunctDiv   = 6'b011010;
  localparam logic [5:0] FunctDivu  = 6'b011011;

  typedef enum logic [3:0] {
    AcAdd, AcSub, AcAnd, AcOr, AcXor, AcNor, AcSlt, AcSltu,
    AcMfhi, AcMflo, AcMult, AcMultu, AcDiv, AcDivu, AcIllegal
  } alucontrol_e;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  function automatic alucontrol_e decode(input logic [1:0] aluop, input logic [5:0] funct);
    alucontrol_e c;
    c = AcIllegal;
    case (aluop)
      AluopAdd: c = AcAdd;
      AluopSub: c = AcSub;
      AluopFunct: begin
        case (funct)
          FunctAdd:   c = AcAdd;
          FunctSub:   c = AcSub;
          FunctAnd:   c = AcAnd;
          FunctOr:    c = AcOr;
          FunctXor:   c = AcXor;
          FunctNor:   c = AcNor;
          FunctSlt:   c = AcSlt;
          FunctSltu:  c = AcSltu;
          FunctMfhi:  c = AcMfhi;
          FunctMflo:  c = AcMflo;
          FunctMult:  c = AcMult;
          FunctMultu: c = AcMultu;
          FunctDiv:   c = AcDiv;
          FunctDivu:  c = AcDivu;
          default:    c = AcIllegal;
        endcase
      end
      default: c = AcIllegal;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: shift-add multiply, restoring divide, one step per
// cycle on magnitudes, with a combinational sign fix-up on the hi/lo outputs.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int unsigned CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt_q;
  logic             active_q, div_q, neg_q, neg_r_q;
  logic [WIDTH-1:0] dvs_q, acc_q, lo_q;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   sum, shifted;
  logic [WIDTH+1:0] diff;
  logic [2*WIDTH-1:0] prod;

  assign mag_a   = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b   = (is_signed && b[WIDTH-1]) ? -b : b;
  assign sum     = {1'b0, acc_q} + {1'b0, dvs_q};
  assign shifted = {acc_q, lo_q[WIDTH-1]};
  assign diff    = {1'b0, shifted} - {2'b00, dvs_q};
  assign prod    = {acc_q, lo_q};
  assign fin     = active_q && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      dvs_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
    end else if (go) begin
      cnt_q    <= '0;
      active_q <= 1'b1;
      div_q    <= is_div;
      // Divide by zero keeps the all-ones quotient regardless of operand signs.
      neg_q    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]) && !(is_div && (b == '0));
      neg_r_q  <= is_signed && a[WIDTH-1];
      dvs_q    <= mag_b;
      acc_q    <= '0;
      lo_q     <= mag_a;
    end else if (active_q) begin
      cnt_q <= cnt_q + CW'(1);
      if (fin) active_q <= 1'b0;
      if (div_q) begin
        if (!diff[WIDTH+1]) begin
          acc_q <= diff[WIDTH-1:0];
          lo_q  <= {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_q <= shifted[WIDTH-1:0];
          lo_q  <= {lo_q[WIDTH-2:0], 1'b0};
        end
      end else if (lo_q[0]) begin
        {acc_q, lo_q} <= {sum, lo_q[WIDTH-1:1]};
      end else begin
        {acc_q, lo_q} <= {1'b0, acc_q, lo_q[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    hi = acc_q;
    lo = lo_q;
    if (div_q) begin
      if (neg_q)   lo = -lo_q;
      if (neg_r_q) hi = -acc_q;
    end else if (neg_q) begin
      {hi, lo} = -prod;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with decode, registered result/zero, and an iterative mult/div unit
// writing hi/lo behind a start/busy/done handshake.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             illegal
);
  alucontrol_e      ctrl;
  state_e           state_q;
  logic             is_mdu, is_div, is_signed, go, fin;
  logic [WIDTH-1:0] alu_y, mdu_hi, mdu_lo;

  assign ctrl      = decode(aluop, funct);
  assign is_mdu    = ctrl inside {AcMult, AcMultu, AcDiv, AcDivu};
  assign is_div    = ctrl inside {AcDiv, AcDivu};
  assign is_signed = ctrl inside {AcMult, AcDiv};
  assign go        = start && (state_q == StIdle) && is_mdu;

  always_comb begin
    alu_y = '0;
    case (ctrl)
      AcAdd:   alu_y = a + b;
      AcSub:   alu_y = a - b;
      AcAnd:   alu_y = a & b;
      AcOr:    alu_y = a | b;
      AcXor:   alu_y = a ^ b;
      AcNor:   alu_y = ~(a | b);
      AcSlt:   alu_y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      AcSltu:  alu_y = {{(WIDTH-1){1'b0}}, a < b};
      AcMfhi:  alu_y = hi;
      AcMflo:  alu_y = lo;
      default: alu_y = '0;
    endcase
  end

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .is_div    (is_div),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .fin       (fin),
    .hi        (mdu_hi),
    .lo        (mdu_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      result  <= '0;
      zero    <= 1'b1;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (ctrl == AcIllegal) begin
              done    <= 1'b1;
              illegal <= 1'b1;
            end else if (is_mdu) begin
              busy    <= 1'b1;
              state_q <= is_div ? StDiv : StMul;
            end else begin
              result <= alu_y;
              zero   <= (alu_y == '0);
              done   <= 1'b1;
            end
          end
        end
        StMul, StDiv: if (fin) state_q <= StFix;
        StFix: begin
          hi      <= mdu_hi;
          lo      <= mdu_lo;
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed and randomized checks of alu_mdu at WIDTH=32 against an arithmetic reference model.
module tb_alu_mdu;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [1:0]    aluop;
  logic [5:0]    funct;
  logic [W-1:0]  a, b, result, hi, lo;
  logic          zero, busy, done, illegal;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] m_result, m_hi, m_lo;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .aluop   (aluop),
    .funct   (funct),
    .a       (a),
    .b       (b),
    .result  (result),
    .zero    (zero),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .illegal (illegal)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: updates m_* per the op and reports whether it is illegal / multicycle.
  task automatic model(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] x,
                       input logic [W-1:0] y, output bit ill, output bit lng);
    longint p, q, r;
    ill = 0;
    lng = 0;
    if (op == 2'b00) m_result = x + y;
    else if (op == 2'b01) m_result = x - y;
    else if (op == 2'b11) ill = 1;
    else begin
      case (fn)
        6'h20: m_result = x + y;
        6'h22: m_result = x - y;
        6'h24: m_result = x & y;
        6'h25: m_result = x | y;
        6'h26: m_result = x ^ y;
        6'h27: m_result = ~(x | y);
        6'h2a: m_result = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        6'h2b: m_result = (x < y) ? 32'd1 : 32'd0;
        6'h10: m_result = m_hi;
        6'h12: m_result = m_lo;
        6'h18: begin
          p = longint'($signed(x)) * longint'($signed(y));
          {m_hi, m_lo} = p;
          lng = 1;
        end
        6'h19: begin
          p = longint'({32'd0, x}) * longint'({32'd0, y});
          {m_hi, m_lo} = p;
          lng = 1;
        end
        6'h1a, 6'h1b: begin
          lng = 1;
          if (y == 0) begin
            m_lo = '1;
            m_hi = x;
          end else begin
            if (fn == 6'h1a) begin
              q = longint'($signed(x)) / longint'($signed(y));
              r = longint'($signed(x)) % longint'($signed(y));
            end else begin
              q = longint'({32'd0, x}) / longint'({32'd0, y});
              r = longint'({32'd0, x}) % longint'({32'd0, y});
            end
            m_lo = q[31:0];
            m_hi = r[31:0];
          end
        end
        default: ill = 1;
      endcase
    end
  endtask

  // Issue one op and check its completion; poke pulses an add while the unit is busy.
  task automatic run(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] x,
                     input logic [W-1:0] y, input bit poke);
    bit ill, lng;
    int busy_n;
    model(op, fn, x, y, ill, lng);
    start = 1'b1;
    aluop = op;
    funct = fn;
    a = x;
    b = y;
    @(posedge clk);
    #1 start = 1'b0;
    if (lng) begin
      busy_n = 0;
      for (int i = 0; i < 100 && !done; i++) begin
        if (busy) busy_n++;
        if (poke && i == 3) begin
          start = 1'b1;
          aluop = 2'b00;
          a = $urandom;
          b = $urandom;
        end
        @(posedge clk);
        #1 start = 1'b0;
      end
      check("mdu_done", done, 1);
      check("mdu_illegal", illegal, 0);
      // busy covers the accept edge through the last iteration edge.
      check("mdu_busy_cycles", busy_n, W + 1);
      check("mdu_busy_clear", busy, 0);
      check("mdu_hi", hi, m_hi);
      check("mdu_lo", lo, m_lo);
      check("mdu_result_kept", result, m_result);
    end else begin
      check("op_done", done, 1);
      check("op_illegal", illegal, ill);
      check("op_busy", busy, 0);
      check("op_result", result, m_result);
      check("op_zero", zero, m_result == 0);
      check("op_hi", hi, m_hi);
      check("op_lo", lo, m_lo);
    end
  endtask

  initial begin
    logic [5:0] fns [16];
    bit saw;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
            6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h3f, 6'h00};
    m_result = '0;
    m_hi = '0;
    m_lo = '0;
    reset = 1'b1;
    start = 1'b0;
    aluop = 2'b00;
    funct = 6'h00;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // Make outputs non-reset, then reset asynchronously mid-cycle.
    run(2'b10, 6'h19, 32'h1234_5678, 32'h0000_0100, 0);
    run(2'b00, 32'h0, 32'd5, 32'd6, 0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_result", result, 0);
    check("async_rst_zero", zero, 1);
    check("async_rst_hi", hi, 0);
    check("async_rst_lo", lo, 0);
    check("async_rst_done", done, 0);
    check("async_rst_illegal", illegal, 0);
    m_result = '0;
    m_hi = '0;
    m_lo = '0;
    @(posedge clk);
    #1 reset = 1'b0;

    run(2'b10, 6'h2a, 32'hFFFF_FFFF, 32'd1, 0);
    check("slt_const", result, 1);
    run(2'b10, 6'h2b, 32'hFFFF_FFFF, 32'd1, 0);
    check("sltu_const", result, 0);
    check("sltu_zero_const", zero, 1);

    run(2'b10, 6'h18, 32'hFFFF_FFFE, 32'd3, 0);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFFA);
    run(2'b10, 6'h12, 32'd0, 32'd0, 0);   // mflo in the done cycle
    check("mflo_fresh", result, 32'hFFFF_FFFA);

    run(2'b10, 6'h1a, -32'sd7, 32'd2, 0);
    check("div_lo_const", lo, 32'hFFFF_FFFD);
    check("div_hi_const", hi, 32'hFFFF_FFFF);
    run(2'b10, 6'h1b, 32'd7, 32'd0, 0);
    check("divu0_lo_const", lo, 32'hFFFF_FFFF);
    check("divu0_hi_const", hi, 32'd7);
    run(2'b10, 6'h1a, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("divovf_lo_const", lo, 32'h8000_0000);
    check("divovf_hi_const", hi, 32'd0);
    run(2'b10, 6'h1a, -32'sd9, 32'd0, 0);

    run(2'b10, 6'h19, 32'hDEAD_BEEF, 32'h0000_1001, 1);   // add poked while busy
    run(2'b10, 6'h10, 32'd0, 32'd0, 0);

    run(2'b11, 6'h20, 32'd1, 32'd2, 0);
    run(2'b10, 6'h3f, 32'd1, 32'd2, 0);

    for (int k = 0; k < 40; k++) begin
      logic [1:0] op;
      logic [W-1:0] x, y;
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) op = 2'b10;
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(0, 15)) - 32'd8;
      run(op, fns[$urandom_range(0, 15)], x, y, 0);
    end

    // Abort a running divide with reset; no done may follow.
    start = 1'b1;
    aluop = 2'b10;
    funct = 6'h1a;
    a = 32'd1000;
    b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_busy_before", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    saw = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) saw = 1;
    end
    check("abort_no_done", saw, 0);
    m_result = '0;
    m_hi = '0;
    m_lo = '0;
    run(2'b01, 6'h00, 32'd3, 32'd5, 0);
    run(2'b00, 6'h00, 32'hFFFF_FFFF, 32'd1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
